// File: rtl/axi_dma_ctrl_pkg.sv
// Shared constants, register map and write payload type for the DMA control slave.
package axi_dma_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SLOT_W = 3;
  localparam int unsigned LEN_W  = 24;
  localparam int unsigned RESP_W = 2;

  // Word slot indices (byte address [4:2])
  localparam logic [SLOT_W-1:0] SLOT_CTRL    = 3'd0;
  localparam logic [SLOT_W-1:0] SLOT_STATUS  = 3'd1;
  localparam logic [SLOT_W-1:0] SLOT_SRC     = 3'd2;
  localparam logic [SLOT_W-1:0] SLOT_DST     = 3'd3;
  localparam logic [SLOT_W-1:0] SLOT_LEN     = 3'd4;
  localparam logic [SLOT_W-1:0] SLOT_VERSION = 3'd5;
  localparam logic [SLOT_W-1:0] SLOT_SCRATCH = 3'd6;

  localparam int unsigned CTRL_START_BIT       = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT      = 1;
  localparam int unsigned STATUS_BUSY_BIT      = 0;
  localparam int unsigned STATUS_DONE_BIT      = 1;
  localparam int unsigned STATUS_START_ERR_BIT = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  localparam logic [DATA_W-1:0] C_VERSION_DEFAULT = 32'h0001_0000;

  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wr_req_t;

  // Byte-lane merge of a write into an existing register value
  function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] old_val,
                                                   input logic [DATA_W-1:0] new_val,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_dma_ctrl_wr_accept.sv
// AW/W hold-and-join: latches each channel independently and raises a commit strobe
// once both are held and no write response is outstanding.
module axi_dma_ctrl_wr_accept
  import axi_dma_ctrl_pkg::*;
#(
  parameter int unsigned C_ADDR_W = 5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [C_ADDR_W-1:0] i_awaddr,
  input  logic                i_awvalid,
  output logic                o_awready,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [STRB_W-1:0]   i_wstrb,
  input  logic                i_wvalid,
  output logic                o_wready,
  input  logic                i_bvalid,
  output logic                o_commit_c,
  output wr_req_t             o_req
);

  logic    r_aw_held;
  logic    r_w_held;
  logic    r_awready;
  logic    r_wready;
  wr_req_t r_req;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_held_nx;
  logic w_w_held_nx;
  logic w_unused;

  assign w_unused   = ^i_awaddr[1:0];
  assign w_aw_hs    = i_awvalid & r_awready;
  assign w_w_hs     = i_wvalid & r_wready;
  assign o_commit_c = r_aw_held & r_w_held & ~i_bvalid;

  // Held flags clear on commit; a handshake can only occur while not held
  always_comb begin
    w_aw_held_nx = r_aw_held;
    w_w_held_nx  = r_w_held;
    if (o_commit_c) begin
      w_aw_held_nx = 1'b0;
      w_w_held_nx  = 1'b0;
    end else begin
      if (w_aw_hs) w_aw_held_nx = 1'b1;
      if (w_w_hs)  w_w_held_nx  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_req     <= '0;
    end else begin
      r_aw_held <= w_aw_held_nx;
      r_w_held  <= w_w_held_nx;
      r_awready <= ~w_aw_held_nx;
      r_wready  <= ~w_w_held_nx;
      if (w_aw_hs) r_req.slot <= i_awaddr[SLOT_W+1:2];
      if (w_w_hs) begin
        r_req.data <= i_wdata;
        r_req.strb <= i_wstrb;
      end
    end
  end

  assign o_awready = r_awready;
  assign o_wready  = r_wready;
  assign o_req     = r_req;

endmodule

// File: rtl/axi_dma_ctrl_slave.sv
// AXI4-Lite register bank for the DMA control path: SRC/DST/LEN/CTRL/STATUS/VERSION,
// start pulse and done interrupt. Optional SCRATCH register at 0x18 via AXI_DMA_CTRL_SCRATCH_EN.
module axi_dma_ctrl_slave
  import axi_dma_ctrl_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] C_VERSION          = C_VERSION_DEFAULT
) (
  input  logic                            m_axi_aclk,
  input  logic                            m_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [31:0]                     dma_src,
  output logic [31:0]                     dma_dst,
  output logic [23:0]                     dma_len,
  output logic                            dma_start,
  input  logic                            dma_busy,
  input  logic                            dma_done,
  output logic                            irq
);

  logic [DATA_W-1:0] r_src;
  logic [DATA_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic              r_irq_en;
  logic              r_done;
  logic              r_start_err;
  logic              r_dma_start;
  logic              r_irq;
  logic              r_bvalid;
  logic [RESP_W-1:0] r_bresp;
  logic              r_rvalid;
  logic              r_arready;
  logic [DATA_W-1:0] r_rdata;
  logic [RESP_W-1:0] r_rresp;
`ifdef AXI_DMA_CTRL_SCRATCH_EN
  logic [DATA_W-1:0] r_scratch;
  logic [DATA_W-1:0] w_scratch_nx;
`endif

  logic              w_commit;
  wr_req_t           w_req;
  logic [DATA_W-1:0] w_src_nx;
  logic [DATA_W-1:0] w_dst_nx;
  logic [LEN_W-1:0]  w_len_nx;
  logic              w_irq_en_nx;
  logic              w_done_nx;
  logic              w_start_err_nx;
  logic              w_start_c;
  logic              w_err_set;
  logic              w_done_clr;
  logic              w_err_clr;
  logic [RESP_W-1:0] w_bresp_nx;
  logic              w_bvalid_nx;
  logic              w_ar_hs;
  logic              w_rvalid_nx;
  logic [SLOT_W-1:0] w_rd_slot;
  logic [DATA_W-1:0] w_rdata_c;
  logic [RESP_W-1:0] w_rresp_c;
  logic              w_unused;

  assign w_unused = ^s_axi_araddr[1:0];

  axi_dma_ctrl_wr_accept #(
    .C_ADDR_W (C_S_AXI_ADDR_WIDTH)
  ) u_wr_accept (
    .i_clk      (m_axi_aclk),
    .i_rst_n    (m_axi_aresetn),
    .i_awaddr   (s_axi_awaddr),
    .i_awvalid  (s_axi_awvalid),
    .o_awready  (s_axi_awready),
    .i_wdata    (s_axi_wdata),
    .i_wstrb    (s_axi_wstrb),
    .i_wvalid   (s_axi_wvalid),
    .o_wready   (s_axi_wready),
    .i_bvalid   (r_bvalid),
    .o_commit_c (w_commit),
    .o_req      (w_req)
  );

  // Write decode: register updates, start/error requests and response code
  always_comb begin
    w_src_nx    = r_src;
    w_dst_nx    = r_dst;
    w_len_nx    = r_len;
    w_irq_en_nx = r_irq_en;
    w_start_c   = 1'b0;
    w_err_set   = 1'b0;
    w_done_clr  = 1'b0;
    w_err_clr   = 1'b0;
    w_bresp_nx  = RESP_OKAY;
`ifdef AXI_DMA_CTRL_SCRATCH_EN
    w_scratch_nx = r_scratch;
`endif
    if (w_commit) begin
      case (w_req.slot)
        SLOT_CTRL: begin
          if (w_req.strb[0]) begin
            w_irq_en_nx = w_req.data[CTRL_IRQ_EN_BIT];
            if (w_req.data[CTRL_START_BIT]) begin
              if (dma_busy) w_err_set = 1'b1;
              else          w_start_c = 1'b1;
            end
          end
        end
        SLOT_STATUS: begin
          if (w_req.strb[0]) begin
            w_done_clr = w_req.data[STATUS_DONE_BIT];
            w_err_clr  = w_req.data[STATUS_START_ERR_BIT];
          end
        end
        SLOT_SRC: w_src_nx = apply_strb(r_src, w_req.data, w_req.strb);
        SLOT_DST: w_dst_nx = apply_strb(r_dst, w_req.data, w_req.strb);
        SLOT_LEN: begin
          for (int i = 0; i < int'(LEN_W / 8); i++) begin
            if (w_req.strb[i]) w_len_nx[8*i +: 8] = w_req.data[8*i +: 8];
          end
        end
        SLOT_VERSION: w_bresp_nx = RESP_OKAY;
`ifdef AXI_DMA_CTRL_SCRATCH_EN
        SLOT_SCRATCH: w_scratch_nx = apply_strb(r_scratch, w_req.data, w_req.strb);
`endif
        default: w_bresp_nx = RESP_SLVERR;
      endcase
    end
  end

  // Sticky status: a same-cycle set beats a W1C
  assign w_done_nx      = dma_done  | (r_done      & ~w_done_clr);
  assign w_start_err_nx = w_err_set | (r_start_err & ~w_err_clr);

  assign w_bvalid_nx = w_commit ? 1'b1 : (r_bvalid & ~s_axi_bready) ? 1'b1 : 1'b0;

  assign w_ar_hs     = s_axi_arvalid & r_arready;
  assign w_rvalid_nx = w_ar_hs ? 1'b1 : (r_rvalid & ~s_axi_rready);
  assign w_rd_slot   = s_axi_araddr[SLOT_W+1:2];

  // Read mux, sampled into rdata/rresp on the AR handshake
  always_comb begin
    w_rdata_c = '0;
    w_rresp_c = RESP_OKAY;
    case (w_rd_slot)
      SLOT_CTRL:    w_rdata_c = DATA_W'({r_irq_en, 1'b0});
      SLOT_STATUS:  w_rdata_c = DATA_W'({r_start_err, r_done, dma_busy});
      SLOT_SRC:     w_rdata_c = r_src;
      SLOT_DST:     w_rdata_c = r_dst;
      SLOT_LEN:     w_rdata_c = DATA_W'(r_len);
      SLOT_VERSION: w_rdata_c = C_VERSION;
`ifdef AXI_DMA_CTRL_SCRATCH_EN
      SLOT_SCRATCH: w_rdata_c = r_scratch;
`endif
      default:      w_rresp_c = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_irq_en    <= 1'b0;
      r_done      <= 1'b0;
      r_start_err <= 1'b0;
      r_dma_start <= 1'b0;
      r_irq       <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_rvalid    <= 1'b0;
      r_arready   <= 1'b0;
      r_rdata     <= '0;
      r_rresp     <= RESP_OKAY;
`ifdef AXI_DMA_CTRL_SCRATCH_EN
      r_scratch   <= '0;
`endif
    end else begin
      r_src       <= w_src_nx;
      r_dst       <= w_dst_nx;
      r_len       <= w_len_nx;
      r_irq_en    <= w_irq_en_nx;
      r_done      <= w_done_nx;
      r_start_err <= w_start_err_nx;
      r_dma_start <= w_start_c;
      r_irq       <= w_done_nx & w_irq_en_nx;
      r_bvalid    <= w_bvalid_nx;
      r_rvalid    <= w_rvalid_nx;
      r_arready   <= ~w_rvalid_nx;
      if (w_commit) r_bresp <= w_bresp_nx;
      if (w_ar_hs) begin
        r_rdata <= w_rdata_c;
        r_rresp <= w_rresp_c;
      end
`ifdef AXI_DMA_CTRL_SCRATCH_EN
      r_scratch   <= w_scratch_nx;
`endif
    end
  end

  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign dma_src       = r_src;
  assign dma_dst       = r_dst;
  assign dma_len       = r_len;
  assign dma_start     = r_dma_start;
  assign irq           = r_irq;

endmodule
